// File: rtl/clk_div_monitor_if.sv
// rtl/clk_div_monitor_if.sv - control and status bundle between a divided-clock monitor and its user
interface clk_div_monitor_if #(
  parameter int CNT_W = 5
);
  logic             enable;
  logic             clk_div;
  logic             err_clr;
  logic             locked;
  logic             err_pulse;
  logic             err_sticky;
  logic             err_tmo;
  logic [CNT_W-1:0] period_meas;
  logic             meas_valid;

  modport master (
    output enable, clk_div, err_clr,
    input  locked, err_pulse, err_sticky, err_tmo, period_meas, meas_valid
  );

  modport slave (
    input  enable, clk_div, err_clr,
    output locked, err_pulse, err_sticky, err_tmo, period_meas, meas_valid
  );
endinterface

// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - checks phase lengths, lock and period of a divided clock sampled in clk_in
module clk_div_monitor #(
  parameter int DIV_N       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 4,
  parameter int TOL         = 0
) (
  input  logic             clk_in,
  input  logic             reset_n,
  clk_div_monitor_if.slave mon
);
  localparam int HALF        = DIV_N / 2;
  localparam int TMO         = 2 * DIV_N;
  localparam int CNT_W       = $clog2(4 * DIV_N) + 1;
  localparam int GOOD_TARGET = 2 * LOCK_CNT;
  localparam int GOOD_W      = $clog2(GOOD_TARGET + 1);

  localparam logic [CNT_W-1:0]  TMO_V    = CNT_W'(TMO);
  localparam logic [CNT_W-1:0]  TMO_M1   = CNT_W'(TMO - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [GOOD_W-1:0] GOOD_END = GOOD_W'(GOOD_TARGET);

  typedef enum logic [1:0] {IDLE, ACQUIRE, CHECK, LOCKED} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   s_div, edge_det, rise_det;
  logic                   phase_ok, timeout;

  logic [CNT_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0]  per_q, per_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic              rise_seen_q, rise_seen_d;
  logic              locked_q, locked_d;
  logic              err_pulse_q, err_pulse_d;
  logic              err_sticky_q, err_sticky_d;
  logic              err_tmo_q, err_tmo_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              meas_valid_q, meas_valid_d;

  assign s_div    = sync_q[SYNC_STAGES-1];
  assign edge_det = s_div ^ prev_q;
  assign rise_det = s_div & ~prev_q;
  // A phase is accepted when its length is within TOL of the nominal half period.
  assign phase_ok = (int'(phase_q) >= HALF - TOL) && (int'(phase_q) <= HALF + TOL);
  // Firing only on the step into TMO keeps a long stall from reporting more than once.
  assign timeout  = !edge_det && (phase_q == TMO_M1);

  // Bring clk_div into the clk_in domain and keep one delayed copy for edge detection.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], mon.clk_div};
      prev_q <= s_div;
    end
  end

  // Monitor state register.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state, phase/period counters, lock and error decisions.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    per_d        = per_q;
    good_d       = good_q;
    rise_seen_d  = rise_seen_q;
    locked_d     = locked_q;
    err_pulse_d  = 1'b0;
    err_tmo_d    = err_tmo_q;
    err_sticky_d = err_sticky_q & ~mon.err_clr;
    period_d     = period_q;
    meas_valid_d = 1'b0;

    if (!mon.enable) begin
      state_d     = IDLE;
      phase_d     = '0;
      per_d       = '0;
      good_d      = '0;
      rise_seen_d = 1'b0;
      locked_d    = 1'b0;
    end else if (state_q == IDLE) begin
      state_d = ACQUIRE;
    end else begin
      if (edge_det)              phase_d = CNT_W'(1);
      else if (phase_q != TMO_V) phase_d = phase_q + 1'b1;

      if (rise_det)               per_d = CNT_W'(1);
      else if (per_q != CNT_MAX)  per_d = per_q + 1'b1;

      if (rise_det) begin
        if (rise_seen_q) begin
          period_d     = per_q;
          meas_valid_d = 1'b1;
        end
        rise_seen_d = 1'b1;
      end

      if (timeout) begin
        state_d     = ACQUIRE;
        err_pulse_d = 1'b1;
        err_tmo_d   = 1'b1;
        locked_d    = 1'b0;
        good_d      = '0;
        rise_seen_d = 1'b0;
      end else if (edge_det) begin
        case (state_q)
          ACQUIRE: begin
            state_d = CHECK;
            good_d  = '0;
          end
          CHECK: begin
            if (phase_ok) begin
              good_d = good_q + 1'b1;
              if (good_q + 1'b1 == GOOD_END) begin
                state_d  = LOCKED;
                locked_d = 1'b1;
              end
            end else begin
              good_d      = '0;
              err_pulse_d = 1'b1;
              err_tmo_d   = 1'b0;
            end
          end
          LOCKED: begin
            if (!phase_ok) begin
              state_d     = CHECK;
              good_d      = '0;
              locked_d    = 1'b0;
              err_pulse_d = 1'b1;
              err_tmo_d   = 1'b0;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    if (err_pulse_d) err_sticky_d = 1'b1;
  end

  // Register counters and all outputs.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      phase_q      <= '0;
      per_q        <= '0;
      good_q       <= '0;
      rise_seen_q  <= 1'b0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_tmo_q    <= 1'b0;
      period_q     <= '0;
      meas_valid_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      per_q        <= per_d;
      good_q       <= good_d;
      rise_seen_q  <= rise_seen_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
      err_tmo_q    <= err_tmo_d;
      period_q     <= period_d;
      meas_valid_q <= meas_valid_d;
    end
  end

  assign mon.locked      = locked_q;
  assign mon.err_pulse   = err_pulse_q;
  assign mon.err_sticky  = err_sticky_q;
  assign mon.err_tmo     = err_tmo_q;
  assign mon.period_meas = period_q;
  assign mon.meas_valid  = meas_valid_q;
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb/tb_clk_div_monitor.sv - directed bench for clk_div_monitor with divide-by-4 and divide-by-2 sources
module tb_clk_div_monitor;
  logic clk_in = 1'b0;
  logic reset_n;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  clk_div_monitor_if #(.CNT_W(5)) if4 ();
  clk_div_monitor_if #(.CNT_W(4)) if2 ();

  clk_div_monitor #(.DIV_N(4)) dut4 (.clk_in(clk_in), .reset_n(reset_n), .mon(if4.slave));
  clk_div_monitor #(.DIV_N(2)) dut2 (.clk_in(clk_in), .reset_n(reset_n), .mon(if2.slave));

  always #5 clk_in = ~clk_in;

  // divide-by-4 source state and expected-period scoreboard
  logic div_run     = 1'b0;
  int   dcnt        = 0;
  int   half_cur    = 2;
  int   stretch_req = 0;
  int   stretch_ack = 0;
  logic rise_valid4 = 1'b0;
  int   last_rise4  = 0;
  int   last_toggle4 = -1;
  int   q4[$];
  int   meas_cnt4 = 0;
  int   err_cnt4  = 0;

  // divide-by-2 source state and scoreboard
  logic run2        = 1'b0;
  int   drop_req    = 0;
  int   drop_ack    = 0;
  logic rise_valid2 = 1'b0;
  int   last_rise2  = 0;
  int   q2[$];
  int   meas_cnt2 = 0;
  int   err_cnt2  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // divide-by-4 generator; pushes the expected period on every rising edge after the first
  always @(posedge clk_in) begin
    cyc++;
    #1;
    if (!reset_n) begin
      if4.clk_div = 1'b0;
      dcnt        = 0;
      half_cur    = 2;
      rise_valid4 = 1'b0;
    end else if (!div_run) begin
      rise_valid4 = 1'b0;
    end else begin
      dcnt++;
      if (dcnt >= half_cur) begin
        dcnt         = 0;
        half_cur     = 2;
        if4.clk_div  = ~if4.clk_div;
        last_toggle4 = cyc;
        if (if4.clk_div) begin
          if (rise_valid4) q4.push_back(cyc - last_rise4);
          rise_valid4 = 1'b1;
          last_rise4  = cyc;
          if (stretch_req != stretch_ack) begin
            stretch_ack = stretch_req;
            half_cur    = 3;
          end
        end
      end
    end
  end

  // divide-by-2 generator; a drop request skips one toggle
  always @(posedge clk_in) begin
    #1;
    if (!reset_n) begin
      if2.clk_div = 1'b0;
      rise_valid2 = 1'b0;
    end else if (!run2) begin
      rise_valid2 = 1'b0;
    end else if (drop_req != drop_ack) begin
      drop_ack = drop_req;
    end else begin
      if2.clk_div = ~if2.clk_div;
      if (if2.clk_div) begin
        if (rise_valid2) q2.push_back(cyc - last_rise2);
        rise_valid2 = 1'b1;
        last_rise2  = cyc;
      end
    end
  end

  // scoreboard pop on measurement pulses, error pulse counting
  always @(negedge clk_in) begin
    int exp;
    if (reset_n === 1'b1) begin
      if (if4.meas_valid === 1'b1) begin
        meas_cnt4++;
        exp = (q4.size() > 0) ? q4.pop_front() : 0;
        check("period_meas4", if4.period_meas, exp);
      end
      if (if2.meas_valid === 1'b1) begin
        meas_cnt2++;
        exp = (q2.size() > 0) ? q2.pop_front() : 0;
        check("period_meas2", if2.period_meas, exp);
      end
      if (if4.err_pulse === 1'b1) err_cnt4++;
      if (if2.err_pulse === 1'b1) err_cnt2++;
    end
  end

  task automatic wait_locked(input int which, input int n, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < n && !ok; i++) begin
      @(negedge clk_in);
      ok = (which == 4) ? if4.locked : if2.locked;
    end
  endtask

  task automatic wait_err(input int which, input int n, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < n && !ok; i++) begin
      @(negedge clk_in);
      ok = (which == 4) ? if4.err_pulse : if2.err_pulse;
    end
  endtask

  task automatic pause_at_fall(output int t, output logic ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 12 && !ok; i++) begin
      @(negedge clk_in);
      if (last_toggle4 == cyc && if4.clk_div == 1'b0) begin
        div_run = 1'b0;
        t       = cyc;
        ok      = 1'b1;
      end
    end
  endtask

  initial begin
    logic ok;
    int   t, m0, e0;

    reset_n     = 1'b0;
    if4.enable  = 1'b0;
    if4.err_clr = 1'b0;
    if2.enable  = 1'b0;
    if2.err_clr = 1'b0;
    repeat (3) @(negedge clk_in);

    check("rst_locked",      if4.locked,      0);
    check("rst_err_sticky",  if4.err_sticky,  0);
    check("rst_period_meas", if4.period_meas, 0);
    check("rst_meas_valid",  if4.meas_valid,  0);
    check("rst_err_tmo",     if4.err_tmo,     0);
    check("rst_locked2",     if2.locked,      0);

    // 1: lock from reset, periods of 4 every 4 cycles
    reset_n    = 1'b1;
    if4.enable = 1'b1;
    div_run    = 1'b1;
    wait_locked(4, 24, ok);
    check("t1_lock_in_24", ok, 1);
    check("t1_err_sticky", if4.err_sticky, 0);
    m0 = meas_cnt4;
    repeat (12) @(negedge clk_in);
    check("t1_meas_per_12cyc", meas_cnt4 - m0, 3);
    check("t1_period", if4.period_meas, 4);

    // 2: one stretched high phase
    e0 = err_cnt4;
    stretch_req++;
    wait_err(4, 14, ok);
    check("t2_err_seen",    ok, 1);
    check("t2_err_tmo",     if4.err_tmo,    0);
    check("t2_err_sticky",  if4.err_sticky, 1);
    check("t2_locked_drop", if4.locked,     0);
    wait_locked(4, 30, ok);
    check("t2_relock", ok, 1);
    check("t2_single_err", err_cnt4 - e0, 1);

    // 3: clk_div stuck low -> single timeout 8 cycles after the last edge
    pause_at_fall(t, ok);
    check("t3_paused", ok, 1);
    e0 = err_cnt4;
    wait_err(4, 16, ok);
    check("t3_tmo_seen",   ok, 1);
    check("t3_tmo_cycle",  cyc, t + 2 + 8);
    check("t3_err_tmo",    if4.err_tmo, 1);
    check("t3_locked",     if4.locked,  0);
    repeat (30) @(negedge clk_in);
    check("t3_one_pulse",  err_cnt4 - e0, 1);
    div_run = 1'b1;
    wait_locked(4, 40, ok);
    check("t3_relock", ok, 1);

    // 4: err_clr alone, then coincident with a new error, then alone again
    check("t4_sticky_before", if4.err_sticky, 1);
    if4.err_clr = 1'b1;
    @(negedge clk_in);
    if4.err_clr = 1'b0;
    check("t4_clr_alone", if4.err_sticky, 0);
    pause_at_fall(t, ok);
    check("t4_paused", ok, 1);
    repeat (9) @(negedge clk_in);
    if4.err_clr = 1'b1;
    @(negedge clk_in);
    if4.err_clr = 1'b0;
    check("t4_pulse_coincident",  if4.err_pulse,  1);
    check("t4_set_wins",          if4.err_sticky, 1);
    @(negedge clk_in);
    check("t4_sticky_holds",      if4.err_sticky, 1);
    div_run = 1'b1;
    wait_locked(4, 40, ok);
    check("t4_relock", ok, 1);
    if4.err_clr = 1'b1;
    @(negedge clk_in);
    if4.err_clr = 1'b0;
    check("t4_clr_later", if4.err_sticky, 0);

    // 5: asynchronous reset while locked, then relock
    div_run = 1'b0;
    repeat (2) @(negedge clk_in);
    check("t5_locked_before", if4.locked, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_async_locked",  if4.locked,      0);
    check("t5_async_period",  if4.period_meas, 0);
    check("t5_async_err_tmo", if4.err_tmo,     0);
    check("t5_async_sticky",  if4.err_sticky,  0);
    q4.delete();
    q2.delete();
    @(negedge clk_in);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_in);
    div_run = 1'b1;
    wait_locked(4, 24, ok);
    check("t5_relock", ok, 1);
    check("t5_err_sticky", if4.err_sticky, 0);

    // 6: divide-by-2 lock, one dropped toggle, relock
    if2.enable = 1'b1;
    run2       = 1'b1;
    wait_locked(2, 30, ok);
    check("t6_lock", ok, 1);
    check("t6_err_sticky", if2.err_sticky, 0);
    m0 = meas_cnt2;
    repeat (8) @(negedge clk_in);
    check("t6_meas_per_8cyc", meas_cnt2 - m0, 4);
    check("t6_period", if2.period_meas, 2);
    e0 = err_cnt2;
    drop_req++;
    wait_err(2, 10, ok);
    check("t6_err_seen", ok, 1);
    check("t6_err_tmo",  if2.err_tmo, 0);
    check("t6_locked",   if2.locked,  0);
    wait_locked(2, 30, ok);
    check("t6_relock", ok, 1);
    check("t6_single_err", err_cnt2 - e0, 1);

    div_run = 1'b0;
    run2    = 1'b0;
    repeat (6) @(negedge clk_in);
    check("q4_drained", q4.size(), 0);
    check("q2_drained", q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
